// File: rtl/uart_fifo_trx.sv
// Full-duplex UART with configurable frame, runtime baud divider, TX/RX FIFOs,
// parity/framing error flags, sticky overrun and internal loopback.
module uart_fifo_trx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [31:0]                   baud_div_i,
  input  logic                          loopback_i,
  input  logic                          uart_rx_i,
  output logic                          uart_tx_o,
  input  logic [DATA_BITS-1:0]          tx_data_i,
  input  logic                          tx_data_vld_i,
  output logic                          tx_data_rdy_o,
  output logic [DATA_BITS-1:0]          rx_data_o,
  output logic [1:0]                    rx_err_o,
  output logic                          rx_data_vld_o,
  input  logic                          rx_data_rdy_i,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level_o,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level_o,
  output logic                          rx_overrun_o,
  input  logic                          overrun_clr_i
);
  localparam int   AW  = $clog2(FIFO_DEPTH);
  localparam int   LW  = AW + 1;
  localparam int   RW  = DATA_BITS + 2;
  localparam logic ODD = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wr, tx_rd;
  logic [LW-1:0]        tx_count;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_push, tx_pop, tx_vld;

  assign tx_data_rdy_o = (tx_count != LW'(FIFO_DEPTH));
  assign tx_vld        = (tx_count != '0);
  assign tx_push       = tx_data_vld_i & tx_data_rdy_o;
  assign tx_head       = tx_mem[tx_rd];
  assign tx_level_o    = tx_count;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + LW'(1);
      else if (tx_pop && !tx_push) tx_count <= tx_count - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr] <= tx_data_i;
  end

  // TX FSM
  state_t               tx_state, tx_state_nxt;
  logic [31:0]          tx_cnt, tx_cnt_nxt, tx_div, tx_div_nxt;
  logic [3:0]           tx_bit, tx_bit_nxt;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
  logic                 tx_par, tx_par_nxt, tx_done, tx_last_stop, tx_line;

  assign tx_done = (tx_cnt == tx_div);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_div   <= tx_div_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      tx_par   <= tx_par_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_div_nxt   = tx_div;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_par_nxt   = tx_par;
    tx_pop       = 1'b0;
    tx_last_stop = 1'b0;
    if (tx_state != S_IDLE) tx_cnt_nxt = tx_done ? '0 : tx_cnt + 32'd1;
    case (tx_state)
      S_START: if (tx_done) begin
        tx_state_nxt = S_DATA;
        tx_bit_nxt   = '0;
      end
      S_DATA: if (tx_done) begin
        tx_shift_nxt = tx_shift >> 1;
        if (tx_bit == 4'(DATA_BITS - 1)) begin
          tx_bit_nxt   = '0;
          tx_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        end else begin
          tx_bit_nxt = tx_bit + 4'd1;
        end
      end
      S_PARITY: if (tx_done) begin
        tx_state_nxt = S_STOP;
        tx_bit_nxt   = '0;
      end
      S_STOP: if (tx_done) begin
        if (tx_bit == 4'(STOP_BITS - 1)) begin
          tx_state_nxt = S_IDLE;
          tx_last_stop = 1'b1;
        end else begin
          tx_bit_nxt = tx_bit + 4'd1;
        end
      end
      default: ;
    endcase
    // Loading on the last stop clock keeps back-to-back frames gap-free.
    if ((tx_state == S_IDLE || tx_last_stop) && tx_vld) begin
      tx_pop       = 1'b1;
      tx_state_nxt = S_START;
      tx_cnt_nxt   = '0;
      tx_div_nxt   = baud_div_i;
      tx_bit_nxt   = '0;
      tx_shift_nxt = tx_head;
      tx_par_nxt   = (^tx_head) ^ ODD;
    end
  end

  always_comb begin
    case (tx_state)
      S_START:  tx_line = 1'b0;
      S_DATA:   tx_line = tx_shift[0];
      S_PARITY: tx_line = tx_par;
      default:  tx_line = 1'b1;
    endcase
  end

  assign uart_tx_o = loopback_i | tx_line;

  // RX synchroniser
  logic rx_meta, rx_s;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= loopback_i ? tx_line : uart_rx_i;
      rx_s    <= rx_meta;
    end
  end

  // RX FIFO
  logic [RW-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr, rx_rd;
  logic [LW-1:0] rx_count;
  logic [RW-1:0] rx_head, rx_q, rx_word;
  logic          rx_push, rx_pop, rx_fifo_rdy, rx_ovr_set;

  assign rx_fifo_rdy   = (rx_count != LW'(FIFO_DEPTH));
  assign rx_data_vld_o = (rx_count != '0);
  assign rx_pop        = rx_data_rdy_i & rx_data_vld_o;
  assign rx_head       = rx_mem[rx_rd];
  assign rx_level_o    = rx_count;
  assign rx_data_o     = rx_q[DATA_BITS-1:0];
  assign rx_err_o      = rx_q[RW-1:DATA_BITS];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_wr        <= '0;
      rx_rd        <= '0;
      rx_count     <= '0;
      rx_q         <= '0;
      rx_overrun_o <= 1'b0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + LW'(1);
      else if (rx_pop && !rx_push) rx_count <= rx_count - LW'(1);
      rx_q <= rx_head;
      if (rx_ovr_set)         rx_overrun_o <= 1'b1;
      else if (overrun_clr_i) rx_overrun_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wr] <= rx_word;
  end

  // RX FSM
  state_t               rx_state, rx_state_nxt;
  logic [31:0]          rx_cnt, rx_cnt_nxt, rx_div, rx_div_nxt, rx_half;
  logic [3:0]           rx_bit, rx_bit_nxt;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt;
  logic                 rx_perr, rx_perr_nxt, rx_wait_hi, rx_wait_hi_nxt, rx_tick;

  assign rx_half = 32'((33'(rx_div) + 33'd1) >> 1);
  assign rx_tick = (rx_state == S_START) ? (rx_cnt == rx_half) : (rx_cnt == rx_div);
  assign rx_word = {~rx_s, rx_perr, rx_shift};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_div     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_perr    <= 1'b0;
      rx_wait_hi <= 1'b0;
    end else begin
      rx_state   <= rx_state_nxt;
      rx_cnt     <= rx_cnt_nxt;
      rx_div     <= rx_div_nxt;
      rx_bit     <= rx_bit_nxt;
      rx_shift   <= rx_shift_nxt;
      rx_perr    <= rx_perr_nxt;
      rx_wait_hi <= rx_wait_hi_nxt;
    end
  end

  always_comb begin
    rx_state_nxt   = rx_state;
    rx_cnt_nxt     = rx_cnt;
    rx_div_nxt     = rx_div;
    rx_bit_nxt     = rx_bit;
    rx_shift_nxt   = rx_shift;
    rx_perr_nxt    = rx_perr;
    rx_wait_hi_nxt = rx_wait_hi;
    rx_push        = 1'b0;
    rx_ovr_set     = 1'b0;
    if (rx_state != S_IDLE) rx_cnt_nxt = rx_tick ? '0 : rx_cnt + 32'd1;
    case (rx_state)
      S_IDLE: begin
        if (rx_s) begin
          rx_wait_hi_nxt = 1'b0;
        end else if (!rx_wait_hi) begin
          rx_state_nxt = S_START;
          rx_cnt_nxt   = '0;
          rx_div_nxt   = baud_div_i;
          rx_perr_nxt  = 1'b0;
        end
      end
      S_START: if (rx_tick) begin
        rx_state_nxt = rx_s ? S_IDLE : S_DATA;
        rx_bit_nxt   = '0;
      end
      S_DATA: if (rx_tick) begin
        rx_shift_nxt = {rx_s, rx_shift[DATA_BITS-1:1]};
        if (rx_bit == 4'(DATA_BITS - 1)) begin
          rx_bit_nxt   = '0;
          rx_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        end else begin
          rx_bit_nxt = rx_bit + 4'd1;
        end
      end
      S_PARITY: if (rx_tick) begin
        rx_perr_nxt  = rx_s ^ (^rx_shift) ^ ODD;
        rx_state_nxt = S_STOP;
      end
      S_STOP: if (rx_tick) begin
        rx_state_nxt   = S_IDLE;
        rx_wait_hi_nxt = ~rx_s;
        if (rx_fifo_rdy) rx_push    = 1'b1;
        else             rx_ovr_set = 1'b1;
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end
endmodule
